// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Fetch FSM encoding, widths and the queue entry layout.
package ifetch_queue_pkg;

    localparam int INSN_W    = 16;
    localparam int WORD_W    = 32;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [INSN_W-1:0] ir;
    } entry_t;

endpackage

// File: rtl/ifetch_queue_hw_fifo.sv
// Halfword instruction queue: one or two pushes and one pop per cycle.
// Flush empties the queue at the clock edge and takes priority over push/pop.
module hw_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_push_lo,
    input  logic          i_push_hi,
    input  entry_t        i_lo,
    input  entry_t        i_hi,
    input  logic          i_pop,
    output entry_t        o_head,
    output logic [CW-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic [PW-1:0] w_wr1;
    entry_t        w_first;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_wr1   = r_wr + PW'(1);
    // A lone push is always the upper halfword when the lower one is skipped
    assign w_first = i_push_lo ? i_lo : i_hi;

    always_ff @(posedge i_clk) begin
        if (!i_flush) begin
            if (i_push_lo || i_push_hi)
                r_mem[r_wr] <= w_first;
            if (i_push_lo && i_push_hi)
                r_mem[w_wr1] <= i_hi;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + PW'(i_push_lo) + PW'(i_push_hi);
            r_rd    <= r_rd + PW'(w_pop);
            r_count <= r_count + CW'(i_push_lo) + CW'(i_push_hi) - CW'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: word reads from unified memory, split into
// halfword instructions, queued and handed to decode over valid/ready.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = DEPTH_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic [15:0] o_ir,
    output logic [31:0] o_ir_pc,
    output logic        o_ir_valid,
    input  logic        i_ir_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_fetch_addr;
    logic          r_skip_lo;
    logic          r_discard;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_room;
    logic          w_room_next;
    logic          w_accept;
    logic          w_pop;
    logic          w_push_lo;
    entry_t        w_lo;
    entry_t        w_hi;
    entry_t        w_head;
    logic          w_unused;

    assign w_unused  = i_redirect_pc[0];

    assign w_pop     = o_ir_valid && i_ir_ready;
    assign w_accept  = (r_state == WAIT) && i_mem_rvalid
                       && !r_discard && !i_redirect;
    assign w_push_lo = w_accept && !r_skip_lo;
    assign w_lo      = {r_fetch_addr, i_mem_rdata[15:0]};
    assign w_hi      = {r_fetch_addr[31:2], 2'b10, i_mem_rdata[31:16]};

    // Request only with two free slots so a full word always fits
    assign w_count_next = i_redirect ? '0 :
        w_count + CW'(w_push_lo) + CW'(w_accept) - CW'(w_pop);
    assign w_room       = w_count <= CW'(DEPTH - 2);
    assign w_room_next  = w_count_next <= CW'(DEPTH - 2);

    hw_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_flush  (i_redirect),
        .i_push_lo(w_push_lo),
        .i_push_hi(w_accept),
        .i_lo     (w_lo),
        .i_hi     (w_hi),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (w_count)
    );

    always_comb begin
        w_next    = r_state;
        o_mem_req = 1'b0;
        unique case (r_state)
            IDLE: if (i_redirect || w_room) w_next = REQ;
            REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_ack)       w_next = WAIT;
                else if (i_redirect) w_next = IDLE;
            end
            WAIT: if (i_mem_rvalid) w_next = w_room_next ? REQ : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_fetch_addr <= {RESET_PC[31:2], 2'b00};
            r_skip_lo    <= RESET_PC[1];
            r_discard    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (i_redirect) begin
                r_fetch_addr <= {i_redirect_pc[31:2], 2'b00};
                r_skip_lo    <= i_redirect_pc[1];
            end else if (w_accept) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
                r_skip_lo    <= 1'b0;
            end
            // A response already in flight at redirect time belongs to the old stream
            if (r_state == REQ && i_mem_ack && i_redirect)
                r_discard <= 1'b1;
            else if (r_state == WAIT)
                r_discard <= i_mem_rvalid ? 1'b0 : (r_discard | i_redirect);
        end
    end

    assign o_mem_addr = {r_fetch_addr[31:2], 2'b00};
    assign o_ir_valid = w_count != '0;
    assign o_ir       = o_ir_valid ? w_head.ir : '0;
    assign o_ir_pc    = o_ir_valid ? w_head.pc : RESET_PC;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: fetch, backpressure, redirects, reset.
module tb_ifetch_queue;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [15:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_queue #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_ack    (mem_ack),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_ir         (ir),
        .o_ir_pc      (ir_pc),
        .o_ir_valid   (ir_valid),
        .i_ir_ready   (ir_ready),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word 0 is the fixed pattern; elsewhere halfword at pc p is p+0x5000
    function automatic logic [31:0] mw(input logic [31:0] a);
        if (a == 32'h0)
            return 32'hBBBB_AAAA;
        return {a[15:0] + 16'h5002, a[15:0] + 16'h5000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        mem_ack = 1'b1;
        tick();
        mem_ack    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = mw(a);
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'h0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_vld"}, 32'(ir_valid), 32'h0);
        chk({tag, "_ir"}, 32'(ir), 32'h0);
        chk({tag, "_pc"}, ir_pc, 32'h0);
    endtask

    initial begin
        rst         = 1'b1;
        mem_ack     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        ir_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #1 rst = 1'b0;
        #10;
        chk_rst("reset");
        rst = 1'b1;
        tick();

        // 1: first fetch, both halfwords delivered back to back
        chk("t1_req", 32'(mem_req), 32'h1);
        chk("t1_addr", mem_addr, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t1_req_wait", 32'(mem_req), 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBBBB_AAAA;
        tick();
        mem_rvalid = 1'b0;
        chk("t1_vld", 32'(ir_valid), 32'h1);
        chk("t1_ir0", 32'(ir), 32'h0000_AAAA);
        chk("t1_pc0", ir_pc, 32'h0);
        chk("t1_next_addr", mem_addr, 32'h4);
        chk("t1_next_req", 32'(mem_req), 32'h1);
        ir_ready = 1'b1;
        tick();
        chk("t1_ir1", 32'(ir), 32'h0000_BBBB);
        chk("t1_pc1", ir_pc, 32'h2);
        chk("t1_addr_hold", mem_addr, 32'h4);
        tick();
        ir_ready = 1'b0;
        chk("t1_empty", 32'(ir_valid), 32'h0);

        // 2: backpressure, two fetches fill the queue then requests stop
        fetch(32'h4);
        chk("t2_req2", 32'(mem_req), 32'h1);
        chk("t2_addr2", mem_addr, 32'h8);
        chk("t2_ir", 32'(ir), 32'h0000_5004);
        fetch(32'h8);
        for (int i = 0; i < 3; i++) begin
            chk("t2_full_noreq", 32'(mem_req), 32'h0);
            tick();
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("t2_pop1_pc", ir_pc, 32'h6);
        chk("t2_pop1_noreq", 32'(mem_req), 32'h0);
        tick();
        chk("t2_pop1_noreq2", 32'(mem_req), 32'h0);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("t2_pop2_pc", ir_pc, 32'h8);
        tick();
        chk("t2_req3", 32'(mem_req), 32'h1);
        chk("t2_addr3", mem_addr, 32'hC);
        fetch(32'hC);
        chk("t2_full_again", 32'(mem_req), 32'h0);
        chk("t2_head", ir_pc, 32'h8);

        // 3: redirect to 0x102 while full
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        chk("t3_flush", 32'(ir_valid), 32'h0);
        chk("t3_req", 32'(mem_req), 32'h1);
        chk("t3_addr", mem_addr, 32'h100);
        fetch(32'h100);
        chk("t3_vld", 32'(ir_valid), 32'h1);
        chk("t3_ir", 32'(ir), 32'h0000_5102);
        chk("t3_pc", ir_pc, 32'h102);
        chk("t3_next_addr", mem_addr, 32'h104);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("t3_only_hi", 32'(ir_valid), 32'h0);

        // 4: redirect while waiting for a response
        mem_ack = 1'b1;
        tick();
        mem_ack     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        chk("t4_wait_noreq", 32'(mem_req), 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = mw(32'h104);
        tick();
        mem_rvalid = 1'b0;
        chk("t4_dropped", 32'(ir_valid), 32'h0);
        chk("t4_req", 32'(mem_req), 32'h1);
        chk("t4_addr", mem_addr, 32'h200);
        fetch(32'h200);
        chk("t4_pc", ir_pc, 32'h200);
        chk("t4_ir", 32'(ir), 32'h0000_5200);
        ir_ready = 1'b1;
        tick();
        chk("t4_pc2", ir_pc, 32'h202);
        tick();
        ir_ready = 1'b0;
        chk("t4_drained", 32'(ir_valid), 32'h0);

        // 5: redirect in the same cycle as ack
        chk("t5_addr_pre", mem_addr, 32'h204);
        mem_ack     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        mem_ack  = 1'b0;
        redirect = 1'b0;
        chk("t5_wait", 32'(mem_req), 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = mw(32'h204);
        tick();
        mem_rvalid = 1'b0;
        chk("t5_dropped", 32'(ir_valid), 32'h0);
        chk("t5_addr", mem_addr, 32'h300);
        fetch(32'h300);
        chk("t5_pc", ir_pc, 32'h300);

        // redirect in REQ without ack, odd target
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0401;
        tick();
        redirect = 1'b0;
        chk("t5b_withdrawn", 32'(mem_req), 32'h0);
        chk("t5b_flush", 32'(ir_valid), 32'h0);
        tick();
        chk("t5b_req", 32'(mem_req), 32'h1);
        chk("t5b_addr", mem_addr, 32'h400);
        fetch(32'h400);
        chk("t5b_pc", ir_pc, 32'h400);
        chk("t5b_ir", 32'(ir), 32'h0000_5400);

        // 6: reset mid-WAIT, stale rvalid afterwards
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_rst("t6_async");
        @(posedge clk);
        #1;
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = mw(32'h404);
        tick();
        mem_rvalid = 1'b0;
        chk("t6_stale", 32'(ir_valid), 32'h0);
        chk("t6_req", 32'(mem_req), 32'h1);
        chk("t6_addr", mem_addr, 32'h0);
        fetch(32'h0);
        chk("t6_ir", 32'(ir), 32'h0000_AAAA);
        chk("t6_pc", ir_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front end that replaces the standalone instruction ROM.
- Issues word-aligned 32-bit reads to the unified memory and splits each returned word into two 16-bit instructions.
- Buffers the instructions in a small halfword queue and presents them one at a time, with their PC, to the decode/control stage over a valid/ready handshake.
- Accepts a redirect, taken jump or reset vector, that flushes all in-flight and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetched instruction; bit 0 must be 0.
- DEPTH, 4, halfword queue entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- o_mem_req  out  1  read request valid.
- o_mem_addr  out  32  request byte address; bits [1:0] always 0.
- i_mem_ack  in  1  memory accepted the request this cycle.
- i_mem_rvalid  in  1  read data valid, exactly one per accepted request, at least 1 cycle after ack.
- i_mem_rdata  in  32  read data, little-endian: halfword at addr[1]=0 is [15:0].
- o_ir  out  16  instruction at head of queue.
- o_ir_pc  out  32  byte address of o_ir.
- o_ir_valid  out  1  head entry valid.
- i_ir_ready  in  1  decode consumes head when o_ir_valid is high.
- i_redirect  in  1  flush and restart fetch.
- i_redirect_pc  in  32  new fetch byte address; bit 0 ignored, treated as 0.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - o_mem_req=0, o_mem_addr=RESET_PC&~3, o_ir_valid=0, o_ir=0, o_ir_pc=RESET_PC.
  - Queue empty, state IDLE, discard=0.
  - skip_lo = RESET_PC[1].
- FSM states:
  - IDLE: go to REQ when free slots ≥ 2. Free slots = DEPTH − occupancy.
  - REQ: o_mem_req=1 and o_mem_addr held stable until i_mem_ack. On ack, go to WAIT.
  - WAIT: on i_mem_rvalid, push data and go to IDLE. IDLE re-evaluates space in the same cycle, so back-to-back requests are possible: REQ on the cycle after rvalid.
- First request after reset deasserts: REQ state in the first clock after reset release.
- Push on rvalid (discard=0):
  - Enqueue halfword [15:0] with pc=fetch_addr, unless skip_lo=1.
  - Then enqueue [31:16] with pc=fetch_addr+2.
  - Clear skip_lo and advance fetch_addr by 4, wrapping modulo 2^32.
  - Both halfwords enter the queue in one cycle.
- Latency:
  - rvalid in cycle N gives o_ir_valid=1 in cycle N+1 if the queue was empty.
  - No combinational path from i_mem_* to o_ir*.
- Pop:
  - o_ir_valid && i_ir_ready removes the head.
  - Push and pop in the same cycle are both honoured.
  - Occupancy never exceeds DEPTH; the 2-slot reservation guarantees this.
- Redirect (i_redirect=1), highest priority:
  - Queue flushed at the clock edge, so o_ir_valid=0 the next cycle.
  - fetch_addr = i_redirect_pc&~3 and skip_lo = i_redirect_pc[1].
  - Any pop in the same cycle is still counted as consumed by decode; the flush discards the remainder.
  - In REQ without ack: request withdrawn, o_mem_req=0 for one cycle, then REQ with the new address.
  - In REQ with ack in the same cycle: go to WAIT with discard=1.
  - In WAIT: set discard=1 and stay in WAIT.
  - rvalid in the same cycle as redirect: data dropped, go to IDLE.
- rvalid with discard=1: data dropped, discard cleared, go to IDLE; normal fetch resumes from fetch_addr.
- Redirect to an odd address: bit 0 is silently cleared. No error output.
- i_mem_rvalid in IDLE or REQ is a protocol violation and is ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2.
  - Default DEPTH.
  - INSN_W=16 and WORD_W=32.
- Sub-module hw_fifo (parameter DEPTH), holding {pc[31:0], ir[15:0]} entries:
  - Push of 1 or 2 entries per cycle, single pop, synchronous flush.
  - Occupancy output.
- Top level holds the FSM, fetch_addr, skip_lo and discard.

Test Plan:
1. Reset with RESET_PC=0, then memory returns 32'hBBBB_AAAA for addr 0 with ack immediate and rvalid 1 cycle later -> o_ir=16'hAAAA, pc=0, then 16'hBBBB, pc=2, on consecutive cycles with i_ir_ready=1; next request addr=4.
2. i_ir_ready held 0, DEPTH=4 -> exactly two requests, to 0 and 4. After the second rvalid, o_mem_req stays 0 until at least 2 pops occur.
3. Redirect to 32'h0000_0102 while the queue is full -> next cycle o_ir_valid=0 and the request goes to 0x100. Only the upper halfword is delivered, with o_ir_pc=0x102.
4. Redirect to 0x200 in WAIT while the response for addr 8 is pending -> the addr 8 data is never presented; the next request is 0x200 and the first o_ir_pc is 0x200.
5. Redirect in the same cycle as i_mem_ack -> the subsequent rvalid data is dropped and a new request for the redirect address follows.
6. Assert i_rst low mid-WAIT, then release -> all outputs return to reset values immediately. The stale rvalid is ignored and fetch restarts at RESET_PC.
